// File: rtl/spi_pkg.sv
// Shared SPI peripheral definitions: byte/bit-counter widths
// and the link-level FSM state encoding.
package spi_pkg;

   localparam int SPI_BYTE_W   = 8;
   localparam int SPI_BITCNT_W = 3;

   typedef enum logic {
      SPI_ST_IDLE   = 1'b0,
      SPI_ST_ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/spi_peripheral_sync.sv
// Multi-flop input synchronizer with a selectable reset level.
// Ports: clk_system_i, reset_n_i (async low), d (async in), q (synced out).
module spi_peripheral_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_system_i,
   input  logic reset_n_i,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff_q;

   always_ff @(posedge clk_system_i or negedge reset_n_i) begin
      if (!reset_n_i) ff_q <= {STAGES{RST_VAL}};
      else            ff_q <= {ff_q[STAGES-2:0], d};
   end

   assign q = ff_q[STAGES-1];

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 target, oversampled in clk_system_i, with byte RX strobe and a
// 1-deep TX holding register (valid/ready). Bit order MSB first unless
// SPI_PERIPH_LSB_FIRST_EN is defined.
// Ports: clk_system_i, reset_n_i | sck_i, cs_n_i, pico_i, poci_o, poci_oe_o |
//        rx_data_o, rx_valid_o | tx_data_i, tx_valid_i, tx_ready_o |
//        underrun_o, busy_o
module spi_peripheral
   import spi_pkg::*;
#(
   parameter int                    SYNC_STAGES = 2,
   parameter logic [SPI_BYTE_W-1:0] DEFAULT_TX  = 8'hFF
) (
   input  logic                  clk_system_i,
   input  logic                  reset_n_i,
   input  logic                  sck_i,
   input  logic                  cs_n_i,
   input  logic                  pico_i,
   output logic                  poci_o,
   output logic                  poci_oe_o,
   output logic [SPI_BYTE_W-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic [SPI_BYTE_W-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic                  underrun_o,
   output logic                  busy_o
);

   logic sck_s, cs_n_s, pico_s;
   logic sck_d, cs_n_d;
   logic sck_rise, sck_fall, cs_fall, cs_rise;

   spi_state_e state_q, state_d;

   logic [SPI_BYTE_W-1:0]   tx_sr_q, rx_sr_q, hold_q;
   logic                    hold_full_q, byte_done_q;
   logic [SPI_BITCNT_W-1:0] bit_cnt_q;

   logic [SPI_BYTE_W-1:0] rx_next, tx_shift, reload_byte;
   logic                  start, act, reload, tx_take;

   spi_peripheral_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .clk_system_i(clk_system_i), .reset_n_i(reset_n_i),
      .d(sck_i), .q(sck_s));

   spi_peripheral_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk_system_i(clk_system_i), .reset_n_i(reset_n_i),
      .d(cs_n_i), .q(cs_n_s));

   spi_peripheral_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_pico (
      .clk_system_i(clk_system_i), .reset_n_i(reset_n_i),
      .d(pico_i), .q(pico_s));

   function automatic logic lead_bit(input logic [SPI_BYTE_W-1:0] b);
`ifdef SPI_PERIPH_LSB_FIRST_EN
      return b[0];
`else
      return b[SPI_BYTE_W-1];
`endif
   endfunction

   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign cs_fall  = ~cs_n_s & cs_n_d;
   assign cs_rise  = cs_n_s & ~cs_n_d;

   always_ff @(posedge clk_system_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= SPI_ST_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SPI_ST_IDLE:   if (cs_fall) state_d = SPI_ST_ACTIVE;
         SPI_ST_ACTIVE: if (cs_rise) state_d = SPI_ST_IDLE;
      endcase
   end

   assign poci_oe_o  = (state_q == SPI_ST_ACTIVE);
   assign busy_o     = (state_q == SPI_ST_ACTIVE);
   assign tx_ready_o = ~hold_full_q;

   // A deselect swallows any sck edge seen in the same synced cycle.
   always_comb begin
      start       = (state_q == SPI_ST_IDLE) & cs_fall;
      act         = (state_q == SPI_ST_ACTIVE) & ~cs_rise;
      reload      = start | (act & sck_fall & byte_done_q);
      reload_byte = hold_full_q ? hold_q : DEFAULT_TX;
      tx_take     = tx_valid_i & ~hold_full_q;
`ifdef SPI_PERIPH_LSB_FIRST_EN
      rx_next  = {pico_s, rx_sr_q[SPI_BYTE_W-1:1]};
      tx_shift = {1'b0, tx_sr_q[SPI_BYTE_W-1:1]};
`else
      rx_next  = {rx_sr_q[SPI_BYTE_W-2:0], pico_s};
      tx_shift = {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
`endif
   end

   always_ff @(posedge clk_system_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         sck_d       <= 1'b0;
         cs_n_d      <= 1'b1;
         tx_sr_q     <= '0;
         rx_sr_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         byte_done_q <= 1'b0;
         bit_cnt_q   <= '0;
         poci_o      <= 1'b0;
         rx_data_o   <= '0;
         rx_valid_o  <= 1'b0;
         underrun_o  <= 1'b0;
      end else begin
         sck_d      <= sck_s;
         cs_n_d     <= cs_n_s;
         rx_valid_o <= 1'b0;
         underrun_o <= 1'b0;

         // Reload only clears a full holding reg; a take only fills an
         // empty one, so a same-cycle take lands after an underrun reload.
         if (tx_take) hold_q <= tx_data_i;
         hold_full_q <= tx_take | (hold_full_q & ~reload);

         if (reload) begin
            tx_sr_q    <= reload_byte;
            poci_o     <= lead_bit(reload_byte);
            underrun_o <= ~hold_full_q;
         end else if (act & sck_fall) begin
            tx_sr_q <= tx_shift;
            poci_o  <= lead_bit(tx_shift);
         end else if ((state_q == SPI_ST_ACTIVE) & cs_rise) begin
            poci_o <= 1'b0;
         end

         if (start) begin
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
         end else if (act & sck_rise) begin
            rx_sr_q   <= rx_next;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (&bit_cnt_q) begin
               rx_data_o   <= rx_next;
               rx_valid_o  <= 1'b1;
               byte_done_q <= 1'b1;
            end
         end else if (act & sck_fall) begin
            byte_done_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_peripheral.sv
// Randomized bench for spi_peripheral: SPI controller model at clk/16
// plus a byte-level reference model of the TX holding register.
module tb_spi_peripheral;

   localparam logic [7:0] DEF = 8'hFF;
`ifdef SPI_PERIPH_LSB_FIRST_EN
   localparam bit LSB = 1'b1;
`else
   localparam bit LSB = 1'b0;
`endif

   logic       clk_system_i = 1'b0;
   logic       reset_n_i    = 1'b0;
   logic       sck_i        = 1'b0;
   logic       cs_n_i       = 1'b0;
   logic       pico_i       = 1'b0;
   logic       poci_o, poci_oe_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic [7:0] tx_data_i    = 8'h00;
   logic       tx_valid_i   = 1'b0;
   logic       tx_ready_o, underrun_o, busy_o;

   int tests = 0;
   int fails = 0;

   logic [7:0] hold_q[$];
   logic [7:0] pico_q[$];
   logic [7:0] exp_rx[$];
   logic [7:0] got_rx[$];
   int         exp_under = 0;
   int         got_under = 0;

   spi_peripheral #(.SYNC_STAGES(2), .DEFAULT_TX(DEF)) dut (
      .clk_system_i(clk_system_i),
      .reset_n_i(reset_n_i),
      .sck_i(sck_i),
      .cs_n_i(cs_n_i),
      .pico_i(pico_i),
      .poci_o(poci_o),
      .poci_oe_o(poci_oe_o),
      .rx_data_o(rx_data_o),
      .rx_valid_o(rx_valid_o),
      .tx_data_i(tx_data_i),
      .tx_valid_i(tx_valid_i),
      .tx_ready_o(tx_ready_o),
      .underrun_o(underrun_o),
      .busy_o(busy_o)
   );

   always #5 clk_system_i = ~clk_system_i;

   always @(negedge clk_system_i) begin
      if (rx_valid_o) got_rx.push_back(rx_data_o);
      if (underrun_o) got_under++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(negedge clk_system_i);
   endtask

   // Each byte slot takes the held byte, else DEFAULT with an underrun.
   function automatic logic [7:0] next_tx();
      if (hold_q.size() > 0) return hold_q.pop_front();
      exp_under++;
      return DEF;
   endfunction

   task automatic load_tx(input logic [7:0] b);
      int n = 0;
      while (!tx_ready_o && n < 50) begin
         wclk(1);
         n++;
      end
      chk("tx_ready_wait", {31'd0, tx_ready_o}, 32'd1);
      tx_data_i  = b;
      tx_valid_i = 1'b1;
      wclk(1);
      tx_valid_i = 1'b0;
      hold_q.push_back(b);
      chk("tx_ready_full", {31'd0, tx_ready_o}, 32'd0);
   endtask

   // nfull whole bytes from pico_q, then optionally a cut-bit partial byte.
   // The last sck fall coincides with cs_n rising so it never reloads.
   task automatic session(input int nfull, input int cut,
                          input bit inj, input logic [7:0] inj_b);
      int         total, nb, idx;
      bit         last;
      logic [7:0] exp_b, pb, got;
      total = nfull + ((cut > 0) ? 1 : 0);
      cs_n_i = 1'b0;
      for (int b = 0; b < total; b++) begin
         exp_b = next_tx();
         if (inj && b == 1) hold_q.push_back(inj_b);
         nb  = (b < nfull) ? 8 : cut;
         pb  = (b < nfull) ? pico_q[b] : 8'($urandom);
         got = 8'h00;
         for (int k = 0; k < nb; k++) begin
            idx = LSB ? k : 7 - k;
            pico_i = pb[idx];
            wclk(8);
            if (k == 0) begin
               chk("tx_ready", {31'd0, tx_ready_o},
                   (hold_q.size() == 0) ? 32'd1 : 32'd0);
               chk("poci_oe", {31'd0, poci_oe_o}, 32'd1);
            end
            sck_i = 1'b1;
            got[idx] = poci_o;
            wclk(8);
            last  = (b == total - 1) && (k == nb - 1);
            sck_i = 1'b0;
            if (last) cs_n_i = 1'b1;
            else if (inj && b == 0 && k == 7) begin
               wclk(2);
               tx_data_i  = inj_b;
               tx_valid_i = 1'b1;
               wclk(1);
               tx_valid_i = 1'b0;
            end
         end
         if (nb == 8) begin
            chk("poci_byte", {24'd0, got}, {24'd0, exp_b});
            exp_rx.push_back(pb);
         end
      end
      wclk(8);
      chk("oe_after", {31'd0, poci_oe_o}, 32'd0);
      chk("busy_after", {31'd0, busy_o}, 32'd0);
      chk("rx_count", got_rx.size(), exp_rx.size());
      for (int i = 0; i < exp_rx.size() && i < got_rx.size(); i++)
         chk("rx_data", {24'd0, got_rx[i]}, {24'd0, exp_rx[i]});
      chk("underruns", got_under, exp_under);
      got_rx.delete();
      exp_rx.delete();
      pico_q.delete();
      wclk(8);
   endtask

   initial begin
      int n;
      wclk(4);
      chk("rst_poci", {31'd0, poci_o}, 32'd0);
      chk("rst_oe", {31'd0, poci_oe_o}, 32'd0);
      chk("rst_rx_data", {24'd0, rx_data_o}, 32'd0);
      chk("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
      chk("rst_tx_ready", {31'd0, tx_ready_o}, 32'd1);
      chk("rst_underrun", {31'd0, underrun_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      reset_n_i = 1'b1;
      void'(next_tx());
      wclk(10);
      chk("rel_rx_count", got_rx.size(), 0);
      chk("rel_busy", {31'd0, busy_o}, 32'd1);
      chk("rel_underruns", got_under, exp_under);
      cs_n_i = 1'b1;
      wclk(10);

      load_tx(8'hA5);
      pico_q.push_back(8'h3C);
      session(1, 0, 1'b0, 8'h00);

      load_tx(8'hA5);
      pico_q.push_back(8'h01);
      pico_q.push_back(8'h02);
      pico_q.push_back(8'h03);
      session(3, 0, 1'b0, 8'h00);

      session(0, 5, 1'b0, 8'h00);
      pico_q.push_back(8'h5A);
      session(1, 0, 1'b0, 8'h00);

      pico_q.push_back(8'h11);
      pico_q.push_back(8'h22);
      pico_q.push_back(8'h33);
      session(3, 0, 1'b1, 8'hC3);

      load_tx(8'h80);
      pico_q.push_back(8'h01);
      session(1, 0, 1'b0, 8'h00);

      for (int s = 0; s < 8; s++) begin
         n = int'($urandom_range(1, 3));
         for (int i = 0; i < n; i++) pico_q.push_back(8'($urandom));
         if ($urandom_range(0, 1) == 1) load_tx(8'($urandom));
         session(n, ($urandom_range(0, 3) == 0) ? 3 : 0, 1'b0, 8'h00);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
